mario_animator: RTL and testbench

MARIO_ANIMATOR -- requirements
Module: mario_animator

---
 rtl/mario_animator.sv | 139 +++++++++++++
 tb/tb_mario_animator.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mario_animator.sv
// Sprite-state sequencer for Mario: walk / fly / clamp / die animation selection,
// paced by frame_tick through one shared per-sprite frame counter.
module mario_animator #(
    parameter int WALK_FRAMES  = 6,
    parameter int CLAMP_FRAMES = 4,
    parameter int DIE_FRAMES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       airborne,
    input  logic       clamp,
    input  logic       die,
    output logic [3:0] animate_state,
    output logic       facing_right,
    output logic       die_done
);

    typedef enum logic [3:0] {
        ST_STAND  = 4'b0000,
        ST_WL1    = 4'b0001,
        ST_WL2    = 4'b0010,
        ST_WL3    = 4'b0011,
        ST_WR1    = 4'b0100,
        ST_WR2    = 4'b0101,
        ST_WR3    = 4'b1110,
        ST_FLY_L  = 4'b0110,
        ST_FLY_R  = 4'b0111,
        ST_CLAMP1 = 4'b1000,
        ST_CLAMP2 = 4'b1001,
        ST_DIE1   = 4'b1010,
        ST_DIE2   = 4'b1011,
        ST_DIE3   = 4'b1100,
        ST_DIE4   = 4'b1101
    } anim_t;

    localparam logic [7:0] W_LAST = 8'(WALK_FRAMES - 1);
    localparam logic [7:0] C_LAST = 8'(CLAMP_FRAMES - 1);
    localparam logic [7:0] D_LAST = 8'(DIE_FRAMES - 1);

    anim_t      r_state;
    anim_t      w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_facing;
    logic       w_facing_next;
    logic       r_die_done;
    logic       w_restart;
    logic       w_dir;
    logic       w_dying;
    logic       w_walk_tick;
    logic       w_clamp_tick;
    logic       w_die_tick;

    assign w_dir        = move_left ^ move_right;
    assign w_dying      = (r_state == ST_DIE1) || (r_state == ST_DIE2) ||
                          (r_state == ST_DIE3) || (r_state == ST_DIE4);
    assign w_walk_tick  = frame_tick && (r_cnt == W_LAST);
    assign w_clamp_tick = frame_tick && (r_cnt == C_LAST);
    assign w_die_tick   = frame_tick && (r_cnt == D_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_STAND;
            r_cnt      <= 8'd0;
            r_facing   <= 1'b1;
            r_die_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_facing   <= w_facing_next;
            r_die_done <= r_die_done | (w_state_next == ST_DIE4);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_facing_next = r_facing;
        w_restart     = 1'b0;
        if (w_dying) begin
            if (w_die_tick) begin
                case (r_state)
                    ST_DIE1: w_state_next = ST_DIE2;
                    ST_DIE2: w_state_next = ST_DIE3;
                    ST_DIE3: w_state_next = ST_DIE4;
                    default: w_state_next = r_state;
                endcase
            end
        end else if (die) begin
            w_state_next = ST_DIE1;
        end else begin
            if (w_dir) w_facing_next = move_right;
            if (clamp) begin
                // re-stomping mid-sequence restarts CLAMP1 even if the sprite is unchanged
                w_state_next = ST_CLAMP1;
                w_restart    = 1'b1;
            end else if (r_state == ST_CLAMP1) begin
                if (w_clamp_tick) w_state_next = ST_CLAMP2;
            end else if (r_state != ST_CLAMP2 || w_clamp_tick) begin
                // free movement; the last CLAMP2 tick falls through here so walking restarts at phase 1
                if (airborne) begin
                    w_state_next = w_facing_next ? ST_FLY_R : ST_FLY_L;
                end else if (!w_dir) begin
                    w_state_next = ST_STAND;
                end else if (move_right) begin
                    case (r_state)
                        ST_WR1:  w_state_next = w_walk_tick ? ST_WR2 : ST_WR1;
                        ST_WR2:  w_state_next = w_walk_tick ? ST_WR3 : ST_WR2;
                        ST_WR3:  w_state_next = w_walk_tick ? ST_WR1 : ST_WR3;
                        default: w_state_next = ST_WR1;
                    endcase
                end else begin
                    case (r_state)
                        ST_WL1:  w_state_next = w_walk_tick ? ST_WL2 : ST_WL1;
                        ST_WL2:  w_state_next = w_walk_tick ? ST_WL3 : ST_WL2;
                        ST_WL3:  w_state_next = w_walk_tick ? ST_WL1 : ST_WL3;
                        default: w_state_next = ST_WL1;
                    endcase
                end
            end
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_restart || (w_state_next != r_state)) begin
            w_cnt_next = 8'd0;
        end else if (frame_tick) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    assign animate_state = r_state;
    assign facing_right  = r_facing;
    assign die_done      = r_die_done;

endmodule

// File: tb/tb_mario_animator.sv
// Self-checking bench for mario_animator: directed scenarios plus a randomized run,
// all compared against a pose/stage model evaluated from the animation rules.
module tb_mario_animator;

    localparam int TW = 2;
    localparam int TC = 3;
    localparam int TD = 2;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic       airborne;
    logic       clamp;
    logic       die;
    logic [3:0] animate_state;
    logic       facing_right;
    logic       die_done;

    int total;
    int bad;

    mario_animator #(
        .WALK_FRAMES (TW),
        .CLAMP_FRAMES(TC),
        .DIE_FRAMES  (TD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .move_left    (move_left),
        .move_right   (move_right),
        .airborne     (airborne),
        .clamp        (clamp),
        .die          (die),
        .animate_state(animate_state),
        .facing_right (facing_right),
        .die_done     (die_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: mode 0 free, 1 clamp, 2 dying; pose -1 none, 0 stand, 1 fly, 2 walk left, 3 walk right
    int m_mode;
    int m_stage;
    int m_ticks;
    int m_pose;
    int m_phase;
    int m_facing;

    logic [3:0] wl_codes [3];
    logic [3:0] wr_codes [3];
    logic [3:0] die_codes [4];

    task automatic model_reset();
        m_mode   = 0;
        m_stage  = 0;
        m_ticks  = 0;
        m_pose   = 0;
        m_phase  = 1;
        m_facing = 1;
    endtask

    task automatic model_free(input logic t, input logic l, input logic r, input logic a);
        int want;
        if (a) want = 1;
        else if (!(l ^ r)) want = 0;
        else want = r ? 3 : 2;
        if (want >= 2 && want == m_pose) begin
            if (t) begin
                m_ticks++;
                if (m_ticks == TW) begin
                    m_ticks = 0;
                    m_phase = (m_phase % 3) + 1;
                end
            end
        end else begin
            m_pose  = want;
            m_phase = 1;
            m_ticks = 0;
        end
    endtask

    task automatic model_step(input logic t, input logic l, input logic r,
                              input logic a, input logic c, input logic d);
        if (m_mode == 2) begin
            if (t && m_stage < 4) begin
                m_ticks++;
                if (m_ticks == TD) begin
                    m_stage++;
                    m_ticks = 0;
                end
            end
        end else if (d) begin
            m_mode  = 2;
            m_stage = 1;
            m_ticks = 0;
        end else begin
            if (l ^ r) m_facing = r ? 1 : 0;
            if (c) begin
                m_mode  = 1;
                m_stage = 1;
                m_ticks = 0;
                m_pose  = -1;
            end else if (m_mode == 1) begin
                if (t) begin
                    m_ticks++;
                    if (m_ticks == TC) begin
                        m_ticks = 0;
                        if (m_stage == 1) begin
                            m_stage = 2;
                        end else begin
                            m_mode = 0;
                            model_free(t, l, r, a);
                        end
                    end
                end
            end else begin
                model_free(t, l, r, a);
            end
        end
    endtask

    function automatic logic [3:0] exp_code();
        if (m_mode == 2) return die_codes[m_stage - 1];
        if (m_mode == 1) return (m_stage == 1) ? 4'b1000 : 4'b1001;
        case (m_pose)
            1:       return (m_facing != 0) ? 4'b0111 : 4'b0110;
            2:       return wl_codes[m_phase - 1];
            3:       return wr_codes[m_phase - 1];
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic exp_done();
        return (m_mode == 2 && m_stage == 4);
    endfunction

    task automatic step(input logic t, input logic l, input logic r, input logic a,
                        input logic c, input logic d, input logic rs);
        frame_tick = t;
        move_left  = l;
        move_right = r;
        airborne   = a;
        clamp      = c;
        die        = d;
        rst        = rs;
        if (rs) model_reset();
        else model_step(t, l, r, a, c, d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        frame_tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
        airborne = 1'b0; clamp = 1'b0; die = 1'b0;
        #1 rst = 1'b1;
        #2;
        model_reset();
        total++;
        if (animate_state !== 4'b0000 || facing_right !== 1'b1 || die_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got state=%b facing=%b done=%b, want 0000 1 0",
                     animate_state, facing_right, die_done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle: got state=%b want 0000", animate_state);
        end
        $display("test_reset: state=%b facing=%b done=%b", animate_state, facing_right, die_done);
    endtask

    task automatic test_walk();
        logic [3:0] seq [3];
        seq[0] = 4'b0101; seq[1] = 4'b1110; seq[2] = 4'b0100;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0100 || facing_right !== 1'b1) begin
            bad++;
            $display("FAIL walk_entry: got state=%b facing=%b want 0100 1", animate_state, facing_right);
        end
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 2 * 4; k++) begin
                step((k % 4) == 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                total++;
                if (animate_state !== exp_code()) begin
                    bad++;
                    $display("FAIL walk_model: got state=%b want %b", animate_state, exp_code());
                end
            end
            total++;
            if (animate_state !== seq[p] || facing_right !== 1'b1) begin
                bad++;
                $display("FAIL walk_phase%0d: got state=%b facing=%b want %b 1",
                         p, animate_state, facing_right, seq[p]);
            end
            $display("test_walk: phase step %0d state=%b", p, animate_state);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0101) begin
            bad++;
            $display("FAIL rev_setup: got state=%b want 0101", animate_state);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0001 || facing_right !== 1'b0) begin
            bad++;
            $display("FAIL rev_switch: got state=%b facing=%b want 0001 0", animate_state, facing_right);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0001) begin
            bad++;
            $display("FAIL rev_hold: got state=%b want 0001", animate_state);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0010 || animate_state !== exp_code()) begin
            bad++;
            $display("FAIL rev_phase2: got state=%b want 0010", animate_state);
        end
        $display("test_reversal: state=%b facing=%b", animate_state, facing_right);
    endtask

    task automatic test_fly();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0110 || facing_right !== 1'b0) begin
            bad++;
            $display("FAIL fly_left: got state=%b facing=%b want 0110 0", animate_state, facing_right);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0001) begin
            bad++;
            $display("FAIL fly_land: got state=%b want 0001", animate_state);
        end
        $display("test_fly: state=%b facing=%b", animate_state, facing_right);
    endtask

    task automatic test_clamp();
        logic l, r, a;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b1000) begin
            bad++;
            $display("FAIL clamp_entry: got state=%b want 1000", animate_state);
        end
        for (int k = 0; k < 2 * TC * 2; k++) begin
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            if (k >= 2 * TC * 2 - 2) begin
                l = 1'b0; r = 1'b1; a = 1'b0;
            end
            step(k[0], l, r, a, 1'b0, 1'b0, 1'b0);
            total++;
            if (animate_state !== exp_code() || facing_right !== m_facing[0]) begin
                bad++;
                $display("FAIL clamp_seq%0d: got state=%b facing=%b want %b %b",
                         k, animate_state, facing_right, exp_code(), m_facing[0]);
            end
            if (k == 2 * TC - 2) begin
                total++;
                if (animate_state !== 4'b1000) begin
                    bad++;
                    $display("FAIL clamp1_hold: got state=%b want 1000", animate_state);
                end
            end
            if (k == 2 * TC - 1) begin
                total++;
                if (animate_state !== 4'b1001) begin
                    bad++;
                    $display("FAIL clamp2_entry: got state=%b want 1001", animate_state);
                end
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0100) begin
            bad++;
            $display("FAIL clamp_exit: got state=%b want 0100", animate_state);
        end
        $display("test_clamp: state=%b facing=%b", animate_state, facing_right);
    endtask

    task automatic test_die();
        logic [3:0] seq [4];
        seq[0] = 4'b1010; seq[1] = 4'b1011; seq[2] = 4'b1100; seq[3] = 4'b1101;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (animate_state !== seq[0] || die_done !== 1'b0) begin
            bad++;
            $display("FAIL die_entry: got state=%b done=%b want 1010 0", animate_state, die_done);
        end
        for (int s = 1; s < 6; s++) begin
            for (int k = 0; k < 2 * TD; k++) begin
                step(k[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0);
            end
            total++;
            if (animate_state !== seq[(s > 3) ? 3 : s] || die_done !== (s >= 3) ||
                facing_right !== 1'b1) begin
                bad++;
                $display("FAIL die_stage%0d: got state=%b done=%b facing=%b want %b %b 1",
                         s, animate_state, die_done, facing_right, seq[(s > 3) ? 3 : s], (s >= 3));
            end
            $display("test_die: stage %0d state=%b done=%b", s, animate_state, die_done);
        end
        do_reset();
        total++;
        if (animate_state !== 4'b0000 || facing_right !== 1'b1 || die_done !== 1'b0) begin
            bad++;
            $display("FAIL die_reset: got state=%b facing=%b done=%b want 0000 1 0",
                     animate_state, facing_right, die_done);
        end
    endtask

    task automatic test_both_and_async();
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0000 || facing_right !== 1'b1) begin
            bad++;
            $display("FAIL both_pressed: got state=%b facing=%b want 0000 1", animate_state, facing_right);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b1000 || facing_right !== 1'b0) begin
            bad++;
            $display("FAIL async_setup: got state=%b facing=%b want 1000 0", animate_state, facing_right);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (animate_state !== 4'b0000 || facing_right !== 1'b1 || die_done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got state=%b facing=%b done=%b want 0000 1 0",
                     animate_state, facing_right, die_done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (animate_state !== 4'b0001) begin
            bad++;
            $display("FAIL async_after: got state=%b want 0001", animate_state);
        end
        $display("test_both_and_async: state=%b facing=%b", animate_state, facing_right);
    endtask

    task automatic test_random();
        int errs_before;
        logic rs;
        errs_before = bad;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rs = ($urandom_range(0, 499) == 0) || (m_mode == 2 && m_stage == 4 && $urandom_range(0, 19) == 0);
            step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 299) == 0, rs);
            total++;
            if (animate_state !== exp_code() || facing_right !== m_facing[0] ||
                die_done !== exp_done() || animate_state === 4'b1111) begin
                bad++;
                $display("FAIL random_%0d: got state=%b facing=%b done=%b want %b %b %b",
                         k, animate_state, facing_right, die_done, exp_code(), m_facing[0], exp_done());
            end
        end
        rst = 1'b0;
        $display("test_random: 3000 cycles, new errors=%0d", bad - errs_before);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        wl_codes[0] = 4'b0001; wl_codes[1] = 4'b0010; wl_codes[2] = 4'b0011;
        wr_codes[0] = 4'b0100; wr_codes[1] = 4'b0101; wr_codes[2] = 4'b1110;
        die_codes[0] = 4'b1010; die_codes[1] = 4'b1011;
        die_codes[2] = 4'b1100; die_codes[3] = 4'b1101;
        model_reset();
        test_reset();
        test_walk();
        test_reversal();
        test_fly();
        test_clamp();
        test_die();
        test_both_and_async();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
